// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and encodings for the writeback-stage register file.
//   REG_W     : width of each architectural register
//   ADDR_W    : register address width
//   NUM_REGS  : number of architectural registers (R0 hardwired to zero)
//   LB_W      : width of the byte constant used by insert operations
//   wb_sel_e  : writeback source select encodings
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_W    = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int LB_W     = 8;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,  // ALU result
        WB_SEL_MEM = 2'd1,  // memory read data
        WB_SEL_LBL = 2'd2,  // replace low byte of current register value
        WB_SEL_LBH = 2'd3   // replace high byte of current register value
    } wb_sel_e;

endpackage : wb_pkg

// File: rtl/wb_data_mux.sv
// -----------------------------------------------------------------------------
// wb_data_mux
// Combinational selection and byte-merge of the writeback value.
// Ports:
//   wb_sel      in  2      source select (wb_sel_e encoding)
//   wb_alu_out  in  REG_W  ALU result
//   wb_mem_out  in  REG_W  memory read data
//   wb_lb_const in  LB_W   byte constant for insert operations
//   cur         in  REG_W  current contents of the destination register
//   wb_data     out REG_W  selected / merged writeback value
// -----------------------------------------------------------------------------
module wb_data_mux
    import wb_pkg::*;
(
    input  logic [1:0]       wb_sel,
    input  logic [REG_W-1:0] wb_alu_out,
    input  logic [REG_W-1:0] wb_mem_out,
    input  logic [LB_W-1:0]  wb_lb_const,
    input  logic [REG_W-1:0] cur,
    output logic [REG_W-1:0] wb_data
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        wb_data = wb_alu_out;
        case (wb_sel_e'(wb_sel))
            WB_SEL_ALU: wb_data = wb_alu_out;
            WB_SEL_MEM: wb_data = wb_mem_out;
            WB_SEL_LBL: wb_data = {cur[REG_W-1:LB_W], wb_lb_const};
            WB_SEL_LBH: wb_data = {wb_lb_const, cur[LB_W-1:0]};
            default:    wb_data = wb_alu_out;
        endcase
    end

endmodule : wb_data_mux

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback-stage register file: selects/merges the MEM/WB value, commits it
// into an 8 x 16-bit architectural register file (R0 hardwired to zero), and
// serves two combinational read ports to decode.
//
// Build option: define WB_BYPASS_EN for write-through bypass on the read ports
// (a read of the register being committed this cycle returns wb_data). Without
// it, reads return the pre-write array value.
//
// Ports:
//   clock        in  1       rising-edge clock
//   reset        in  1       synchronous active-high, clears all registers
//   wb_wr_en     in  1       commit enable for this cycle's writeback
//   wb_sel       in  2       source select (wb_sel_e)
//   wb_fwd_reg   in  ADDR_W  destination register
//   wb_mem_out   in  REG_W   memory read data
//   wb_alu_out   in  REG_W   ALU result
//   wb_lb_const  in  8       byte constant for insert operations
//   rd_addr_a/b  in  ADDR_W  decode read addresses
//   rd_data_a/b  out REG_W   read data
//   wb_data      out REG_W   value selected this cycle (for forwarding)
//   wb_commit    out 1       high when the array is actually updated
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_wr_en,
    input  logic [1:0]        wb_sel,
    input  logic [ADDR_W-1:0] wb_fwd_reg,
    input  logic [REG_W-1:0]  wb_mem_out,
    input  logic [REG_W-1:0]  wb_alu_out,
    input  logic [LB_W-1:0]   wb_lb_const,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [REG_W-1:0]  rd_data_a,
    output logic [REG_W-1:0]  rd_data_b,
    output logic [REG_W-1:0]  wb_data,
    output logic              wb_commit
);

    logic [REG_W-1:0] regs_q [NUM_REGS];
    logic [REG_W-1:0] regs_d [NUM_REGS];
    logic [REG_W-1:0] cur;
    logic [REG_W-1:0] arr_a;
    logic [REG_W-1:0] arr_b;

    // R0 always reads as zero, so inserts targeting R0 merge into 0.
    assign cur = (wb_fwd_reg == '0) ? '0 : regs_q[wb_fwd_reg];

    wb_data_mux u_mux (
        .wb_sel      (wb_sel),
        .wb_alu_out  (wb_alu_out),
        .wb_mem_out  (wb_mem_out),
        .wb_lb_const (wb_lb_const),
        .cur         (cur),
        .wb_data     (wb_data)
    );

    // Writes to R0 are dropped; reset suppresses the commit indication too.
    assign wb_commit = wb_wr_en & (wb_fwd_reg != '0) & ~reset;

    always_comb begin
        regs_d = regs_q;
        if (wb_commit) begin
            regs_d[wb_fwd_reg] = wb_data;
        end
    end

    // NOTE: the array is deliberately reset: architectural state must read 0
    // after reset. State updates use non-blocking assignments so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign arr_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign arr_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];

`ifdef WB_BYPASS_EN
    // wb_commit is never set for R0, so R0 reads stay zero under bypass.
    assign rd_data_a = (wb_commit && (rd_addr_a == wb_fwd_reg)) ? wb_data : arr_a;
    assign rd_data_b = (wb_commit && (rd_addr_b == wb_fwd_reg)) ? wb_data : arr_b;
`else
    assign rd_data_a = arr_a;
    assign rd_data_b = arr_b;
`endif

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Self-checking bench for wb_regfile. Stimulus computes the expected outputs
// from a plain array model of the architectural registers and queues them;
// a monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        wb_wr_en;
    logic [1:0]  wb_sel;
    logic [2:0]  wb_fwd_reg;
    logic [15:0] wb_mem_out;
    logic [15:0] wb_alu_out;
    logic [7:0]  wb_lb_const;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] wb_data;
    logic        wb_commit;

    wb_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .wb_wr_en    (wb_wr_en),
        .wb_sel      (wb_sel),
        .wb_fwd_reg  (wb_fwd_reg),
        .wb_mem_out  (wb_mem_out),
        .wb_alu_out  (wb_alu_out),
        .wb_lb_const (wb_lb_const),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .wb_data     (wb_data),
        .wb_commit   (wb_commit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] data;
        logic        commit;
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rd_ok;
        bit          data_ok;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model[8];
    bit          model_ok = 1'b0;
    int          tests    = 0;
    int          fails    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".wb_commit"}, {15'd0, wb_commit}, {15'd0, e.commit});
            if (e.data_ok) check({e.tag, ".wb_data"}, wb_data, e.data);
            if (e.rd_ok) begin
                check({e.tag, ".rd_data_a"}, rd_data_a, e.ra);
                check({e.tag, ".rd_data_b"}, rd_data_b, e.rb);
            end
        end
    end

    // Drive one cycle of inputs and queue what the specification says the
    // outputs must be during that cycle; then advance the register model.
    task automatic drive(input bit rst, input bit wr, input logic [1:0] sel,
                         input logic [2:0] fwd, input logic [15:0] mem,
                         input logic [15:0] alu, input logic [7:0] lb,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input string tag);
        exp_t        e;
        logic [15:0] cur;
        @(posedge clock);
        #1;
        reset       = rst;
        wb_wr_en    = wr;
        wb_sel      = sel;
        wb_fwd_reg  = fwd;
        wb_mem_out  = mem;
        wb_alu_out  = alu;
        wb_lb_const = lb;
        rd_addr_a   = ra;
        rd_addr_b   = rb;

        cur = (fwd == 3'd0) ? 16'h0000 : model[fwd];
        case (sel)
            2'd0:    e.data = alu;
            2'd1:    e.data = mem;
            2'd2:    e.data = {cur[15:8], lb};
            default: e.data = {lb, cur[7:0]};
        endcase
        e.commit  = wr && (fwd != 3'd0) && !rst;
        e.ra      = (ra == 3'd0) ? 16'h0000 : model[ra];
        e.rb      = (rb == 3'd0) ? 16'h0000 : model[rb];
`ifdef WB_BYPASS_EN
        if (e.commit && ra == fwd) e.ra = e.data;
        if (e.commit && rb == fwd) e.rb = e.data;
`endif
        e.rd_ok   = model_ok;
        e.data_ok = model_ok || (sel < 2'd2);
        e.tag     = tag;
        exp_q.push_back(e);

        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
            model_ok = 1'b1;
        end else if (e.commit) begin
            model[fwd] = e.data;
        end
    endtask

    initial begin
        reset       = 1'b1;
        wb_wr_en    = 1'b0;
        wb_sel      = 2'd0;
        wb_fwd_reg  = 3'd0;
        wb_mem_out  = 16'h0000;
        wb_alu_out  = 16'h0000;
        wb_lb_const = 8'h00;
        rd_addr_a   = 3'd0;
        rd_addr_b   = 3'd0;

        // Reset, with a write to R3 held during reset that must be discarded.
        drive(1, 1, 2'd0, 3'd3, 16'h0000, 16'hBEEF, 8'h00, 3'd3, 3'd0, "rst_wr");
        drive(1, 1, 2'd0, 3'd3, 16'h0000, 16'hBEEF, 8'h00, 3'd3, 3'd0, "rst_wr2");
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'(i), 3'(7 - i), "rst_read");
        end

        // Plain ALU write, visible next cycle.
        drive(0, 1, 2'd0, 3'd5, 16'h0000, 16'h1234, 8'h00, 3'd5, 3'd5, "alu_wr");
        drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'd5, 3'd0, "alu_rd");

        // Byte inserts on R2, back to back.
        drive(0, 1, 2'd0, 3'd2, 16'h0000, 16'hA5A5, 8'h00, 3'd2, 3'd0, "r2_set");
        drive(0, 1, 2'd2, 3'd2, 16'h0000, 16'h0000, 8'h3C, 3'd2, 3'd2, "lbl");
        drive(0, 1, 2'd3, 3'd2, 16'h0000, 16'h0000, 8'h7E, 3'd2, 3'd2, "lbh");
        drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'd2, 3'd0, "lb_rd");

        // Write to R0 dropped but wb_data still shows the value; insert on R0.
        drive(0, 1, 2'd0, 3'd0, 16'h0000, 16'hFFFF, 8'h00, 3'd0, 3'd0, "r0_wr");
        drive(0, 1, 2'd3, 3'd0, 16'h0000, 16'h0000, 8'hC3, 3'd0, 3'd0, "r0_ins");
        drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'd0, 3'd0, "r0_rd");

        // Same-cycle write/read of R4 (bypass-dependent), then next cycle.
        drive(0, 1, 2'd0, 3'd4, 16'h0000, 16'h0F0F, 8'h00, 3'd1, 3'd4, "byp_wr");
        drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'd1, 3'd4, "byp_rd");

        // Disabled write of memory data to R6.
        drive(0, 0, 2'd1, 3'd6, 16'h5555, 16'h0000, 8'h00, 3'd6, 3'd6, "wr_off");
        drive(0, 0, 2'd0, 3'd1, 16'h0000, 16'h0000, 8'h00, 3'd6, 3'd6, "wr_off_rd");

        // Randomized traffic with occasional mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
        end

        // Let the monitor drain, bounded.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clock);
        @(posedge clock);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_regfile
